// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: shares one Wishbone classic slave port between two masters
// (m0 = instruction fetch, m1 = data memory). One single transfer per grant.
// The grant is registered and takes effect one cycle after arbitration in IDLE.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to build the ack-timeout counter.
module wb_arbiter_2m #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int RR_MODE        = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m0_wb_cyc_i,
   input  logic                    m0_wb_stb_i,
   input  logic                    m0_wb_we_i,
   input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
   output logic                    m0_wb_ack_o,
   output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
   input  logic                    m1_wb_cyc_i,
   input  logic                    m1_wb_stb_i,
   input  logic                    m1_wb_we_i,
   input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
   output logic                    m1_wb_ack_o,
   output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
   output logic                    s_wb_cyc_o,
   output logic                    s_wb_stb_o,
   output logic                    s_wb_we_o,
   output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
   output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
   input  logic                    s_wb_ack_i,
   input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
   output logic [1:0]              grant_o,
   output logic                    timeout_o
);

   // Encoding chosen so the state bits are the one-hot grant directly.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUS_M0 = 2'b01,
      BUS_M1 = 2'b10
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;     // last completed owner: 0 = m0, 1 = m1
   logic   req0, req1;
   logic   owner_cyc;
   logic   wd_hit;             // watchdog expiry this cycle

   assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
   assign req1 = m1_wb_cyc_i & m1_wb_stb_i;
   assign owner_cyc = (state_q == BUS_M0) ? m0_wb_cyc_i : m1_wb_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;
   logic        timeout_q, timeout_d;

   assign wd_hit = (state_q != IDLE) && owner_cyc && !s_wb_ack_i &&
                   (wd_q == 16'(TIMEOUT_CYCLES - 1));

   // Watchdog: held at 0 in IDLE so each grant starts from zero; flag is sticky.
   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q | wd_hit;
      if (state_q == IDLE) begin
         wd_d = '0;
      end else if (!s_wb_ack_i) begin
         wd_d = wd_q + 16'd1;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign wd_hit    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // State and last-grant registers; last-grant resets to m1 so the first RR tie goes to m0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Next-state: arbitrate in IDLE; leave the bus on ack, abort or watchdog expiry.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               if (RR_MODE != 0) state_d = last_q ? BUS_M0 : BUS_M1;
               else              state_d = BUS_M1;
            end else if (req0) begin
               state_d = BUS_M0;
            end else if (req1) begin
               state_d = BUS_M1;
            end
         end
         BUS_M0, BUS_M1: begin
            if (!owner_cyc) begin
               state_d = IDLE;
            end else if (s_wb_ack_i || wd_hit) begin
               state_d = IDLE;
               last_d  = (state_q == BUS_M1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: mux the owner onto the slave port and route ack back to it only.
   always_comb begin
      s_wb_cyc_o  = 1'b0;
      s_wb_stb_o  = 1'b0;
      s_wb_we_o   = 1'b0;
      s_wb_adr_o  = '0;
      s_wb_dat_o  = '0;
      s_wb_sel_o  = '0;
      m0_wb_ack_o = 1'b0;
      m1_wb_ack_o = 1'b0;
      m0_wb_dat_o = s_wb_dat_i;
      m1_wb_dat_o = s_wb_dat_i;
      grant_o     = 2'b00;
      case (state_q)
         BUS_M0: begin
            grant_o     = 2'b01;
            s_wb_cyc_o  = m0_wb_cyc_i;
            s_wb_stb_o  = m0_wb_stb_i;
            s_wb_we_o   = m0_wb_we_i;
            s_wb_adr_o  = m0_wb_adr_i;
            s_wb_dat_o  = m0_wb_dat_i;
            s_wb_sel_o  = m0_wb_sel_i;
            m0_wb_ack_o = s_wb_ack_i;
            if (wd_hit) begin
               s_wb_cyc_o  = 1'b0;
               s_wb_stb_o  = 1'b0;
               m0_wb_ack_o = 1'b1;
               m0_wb_dat_o = '0;
            end
         end
         BUS_M1: begin
            grant_o     = 2'b10;
            s_wb_cyc_o  = m1_wb_cyc_i;
            s_wb_stb_o  = m1_wb_stb_i;
            s_wb_we_o   = m1_wb_we_i;
            s_wb_adr_o  = m1_wb_adr_i;
            s_wb_dat_o  = m1_wb_dat_i;
            s_wb_sel_o  = m1_wb_sel_i;
            m1_wb_ack_o = s_wb_ack_i;
            if (wd_hit) begin
               s_wb_cyc_o  = 1'b0;
               s_wb_stb_o  = 1'b0;
               m1_wb_ack_o = 1'b1;
               m1_wb_dat_o = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: instance 0 uses fixed priority, instance 1 round-robin.
// Master/slave signals are packed per instance: master index = 2*k + m.
module tb_wb_arbiter_2m;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]        cyc = '0, stb = '0, we = '0, ack;
   logic [3:0][31:0]  adr = '0, dat = '0, rdat;
   logic [3:0][3:0]   sel = '0;
   logic [1:0]        s_cyc, s_stb, s_we, tmo;
   logic [1:0][31:0]  s_adr, s_dat;
   logic [1:0][3:0]   s_sel;
   logic [1:0]        s_ack = '0;
   logic [1:0][31:0]  s_rdat = '0;
   logic [1:0][1:0]   grant;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(k), .TIMEOUT_CYCLES(8)) u_dut (
         .clk(clk), .reset(reset),
         .m0_wb_cyc_i(cyc[2*k]), .m0_wb_stb_i(stb[2*k]), .m0_wb_we_i(we[2*k]),
         .m0_wb_adr_i(adr[2*k]), .m0_wb_dat_i(dat[2*k]), .m0_wb_sel_i(sel[2*k]),
         .m0_wb_ack_o(ack[2*k]), .m0_wb_dat_o(rdat[2*k]),
         .m1_wb_cyc_i(cyc[2*k+1]), .m1_wb_stb_i(stb[2*k+1]), .m1_wb_we_i(we[2*k+1]),
         .m1_wb_adr_i(adr[2*k+1]), .m1_wb_dat_i(dat[2*k+1]), .m1_wb_sel_i(sel[2*k+1]),
         .m1_wb_ack_o(ack[2*k+1]), .m1_wb_dat_o(rdat[2*k+1]),
         .s_wb_cyc_o(s_cyc[k]), .s_wb_stb_o(s_stb[k]), .s_wb_we_o(s_we[k]),
         .s_wb_adr_o(s_adr[k]), .s_wb_dat_o(s_dat[k]), .s_wb_sel_o(s_sel[k]),
         .s_wb_ack_i(s_ack[k]), .s_wb_dat_i(s_rdat[k]),
         .grant_o(grant[k]), .timeout_o(tmo[k])
      );
   end

   int n_cmp = 0;
   int n_err = 0;
   // Reference model state: last completed owner per instance and arbitration mode.
   int last_m [2] = '{1, 1};
   int rr     [2] = '{0, 1};
   int w;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner by the arbitration rules: a lone requester wins; ties go to m1 or alternate.
   function automatic int pick(input int k, input bit r0, input bit r1);
      if (r0 && !r1) return 0;
      if (r1 && !r0) return 1;
      if (rr[k] != 0) return (last_m[k] == 1) ? 0 : 1;
      return 1;
   endfunction

   task automatic set_req(input int k, input int m, input bit on, input bit w_e,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc[2*k+m] = on; stb[2*k+m] = on;
      we[2*k+m] = w_e; adr[2*k+m] = a; dat[2*k+m] = d; sel[2*k+m] = s;
   endtask

   task automatic rand_req(input int k, input int m);
      set_req(k, m, 1'b1, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15, 1)));
   endtask

   // One granted transfer on instance k; called at a negedge with the DUT in IDLE.
   // lat: wait cycles before ack; late: master raised during the transfer (-1 none);
   // abort: owner drops cyc instead of receiving ack.
   task automatic transfer(input int k, input int lat, input int late, input bit abort,
                           input logic [31:0] rd, output int win);
      int o;
      win = pick(k, cyc[2*k], cyc[2*k+1]);
      o = 1 - win;
      #1 chk("grant_before_edge", grant[k], 2'b00);
      @(posedge clk); #1;
      chk("grant", grant[k], (win == 1) ? 2'b10 : 2'b01);
      chk("s_cyc", s_cyc[k], 1'b1);
      chk("s_stb", s_stb[k], 1'b1);
      chk("s_we", s_we[k], we[2*k+win]);
      chk("s_adr", s_adr[k], adr[2*k+win]);
      chk("s_dat", s_dat[k], dat[2*k+win]);
      chk("s_sel", s_sel[k], sel[2*k+win]);
      if (late >= 0) rand_req(k, late);
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #1;
         chk("grant_held", grant[k], (win == 1) ? 2'b10 : 2'b01);
         chk("ack_wait", ack[2*k+win], 1'b0);
         chk("ack_other_wait", ack[2*k+o], 1'b0);
      end
      @(negedge clk);
      if (abort) begin
         cyc[2*k+win] = 1'b0; stb[2*k+win] = 1'b0;
         #1 chk("abort_s_cyc", s_cyc[k], 1'b0);
         chk("abort_ack", ack[2*k+win], 1'b0);
         @(posedge clk); #1;
         chk("abort_idle", grant[k], 2'b00);
      end else begin
         s_ack[k] = 1'b1; s_rdat[k] = rd;
         #1 chk("ack_owner", ack[2*k+win], 1'b1);
         chk("ack_other", ack[2*k+o], 1'b0);
         chk("rdat_owner", rdat[2*k+win], rd);
         @(posedge clk); #1;
         s_ack[k] = 1'b0;
         cyc[2*k+win] = 1'b0; stb[2*k+win] = 1'b0;
         last_m[k] = win;
         chk("idle_after_ack", grant[k], 2'b00);
         chk("idle_s_cyc", s_cyc[k], 1'b0);
      end
   endtask

   // Randomized rounds on one instance, then drain any pending request.
   task automatic rand_rounds(input int k, input int n);
      int wn;
      for (int r = 0; r < n; r++) begin
         @(negedge clk);
         if (cyc[2*k] == 0 && cyc[2*k+1] == 0) begin
            rand_req(k, $urandom_range(1));
         end
         for (int m = 0; m < 2; m++)
            if (cyc[2*k+m] == 0 && $urandom_range(1) == 1) rand_req(k, m);
         transfer(k, $urandom_range(3), -1, ($urandom_range(7) == 0), $urandom, wn);
      end
      while (cyc[2*k] || cyc[2*k+1]) begin
         @(negedge clk);
         transfer(k, $urandom_range(2), -1, 1'b0, $urandom, wn);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_grant", grant[k], 2'b00);
         chk("rst_s_cyc", s_cyc[k], 1'b0);
         chk("rst_tmo", tmo[k], 1'b0);
         chk("rst_acks", {ack[2*k+1], ack[2*k]}, 2'b00);
      end
      @(negedge clk); reset = 1'b1;

      // m0 alone read, slave acks 2 cycles after strobe with 0x13.
      @(negedge clk);
      set_req(0, 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
      transfer(0, 2, -1, 1'b0, 32'h0000_0013, w);
      chk("m0_only_winner", w, 0);

      // Fixed priority ties: m1 first, then m0, four times.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rand_req(0, 0); rand_req(0, 1);
         transfer(0, $urandom_range(2), -1, 1'b0, $urandom, w);
         chk("fp_first_m1", w, 1);
         @(negedge clk);
         transfer(0, $urandom_range(2), -1, 1'b0, $urandom, w);
         chk("fp_second_m0", w, 0);
      end

      // Round-robin with both masters requesting continuously: 01,10,01,10.
      @(negedge clk);
      rand_req(1, 0); rand_req(1, 1);
      for (int i = 0; i < 4; i++) begin
         transfer(1, $urandom_range(2), -1, 1'b0, $urandom, w);
         chk("rr_alternate", w, i % 2);
         @(negedge clk);
         rand_req(1, w);
      end
      transfer(1, 0, -1, 1'b0, $urandom, w);
      @(negedge clk);
      transfer(1, 0, -1, 1'b0, $urandom, w);

      // m1 write with m0 arriving mid-transfer; m0 is served after the IDLE gap.
      @(negedge clk);
      set_req(0, 1, 1'b1, 1'b1, 32'h8010_0000, 32'hDEAD_BEEF, 4'hF);
      transfer(0, 1, 0, 1'b0, $urandom, w);
      chk("write_winner", w, 1);
      @(negedge clk);
      transfer(0, 0, -1, 1'b0, $urandom, w);
      chk("held_m0_served", w, 0);

      // Abort on RR instance: last-grant unchanged so the next tie follows it.
      @(negedge clk);
      rand_req(1, 0);
      transfer(1, 1, -1, 1'b1, 32'h0, w);
      @(negedge clk);
      rand_req(1, 0); rand_req(1, 1);
      transfer(1, 0, -1, 1'b0, $urandom, w);
      chk("rr_after_abort", w, 0);
      @(negedge clk);
      transfer(1, 0, -1, 1'b0, $urandom, w);

      // Stray slave ack in IDLE is ignored.
      @(negedge clk);
      s_ack[0] = 1'b1; s_rdat[0] = 32'h1234_5678;
      #1 chk("stray_acks", {ack[1], ack[0]}, 2'b00);
      chk("stray_s_cyc", s_cyc[0], 1'b0);
      @(posedge clk); #1;
      chk("stray_grant", grant[0], 2'b00);
      s_ack[0] = 1'b0;

      // Asynchronous reset while BUS_M0 waits for ack.
      @(negedge clk);
      rand_req(0, 0);
      @(posedge clk); #1;
      chk("pre_rst_grant", grant[0], 2'b01);
      #2 reset = 1'b0;
      #1 chk("rst_mid_s_cyc", s_cyc[0], 1'b0);
      chk("rst_mid_s_stb", s_stb[0], 1'b0);
      chk("rst_mid_grant", grant[0], 2'b00);
      chk("rst_mid_ack", ack[0], 1'b0);
      last_m[0] = 1; last_m[1] = 1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      rand_req(0, 0);
      transfer(0, 1, -1, 1'b0, $urandom, w);
      chk("post_rst_m0", w, 0);

      // Randomized traffic on both instances.
      rand_rounds(0, 30);
      rand_rounds(1, 30);

`ifdef WB_ARB_TIMEOUT_EN
      // Slave never acks m0: synthetic ack with zero data on the 8th BUS_M0 cycle.
      @(negedge clk);
      rand_req(0, 0);
      s_rdat[0] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      chk("to_grant", grant[0], 2'b01);
      for (int i = 1; i < 8; i++) begin
         chk("to_no_ack_yet", ack[0], 1'b0);
         @(posedge clk); #1;
      end
      chk("to_ack", ack[0], 1'b1);
      chk("to_dat_zero", rdat[0], 32'h0);
      chk("to_s_cyc", s_cyc[0], 1'b0);
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      last_m[0] = 0;
      chk("to_idle", grant[0], 2'b00);
      chk("to_flag", tmo[0], 1'b1);
      @(negedge clk);
      rand_req(0, 1);
      transfer(0, 2, -1, 1'b0, $urandom, w);
      chk("to_m1_after", w, 1);
      chk("to_flag_sticky", tmo[0], 1'b1);
`else
      chk("tmo_tied0_i0", tmo[0], 1'b0);
      chk("tmo_tied0_i1", tmo[1], 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Shares one Wishbone classic slave port between two CPU masters.
- m0 is the instruction-fetch master (IF); m1 is the data-memory master (MEM).
- Sits between the CPU core's two Wishbone master ports and the single SRAM/peripheral bus.
- Grants one master per single transfer; selects fixed-priority or round-robin arbitration by parameter.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; select width is DATA_WIDTH/8
RR_MODE, 0, 0 = fixed priority (m1 wins ties); 1 = round-robin on ties
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with WB_ARB_TIMEOUT_EN; legal range 1..65535

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0
m0_wb_cyc_i, m1_wb_cyc_i  input  1 each  master cycle
m0_wb_stb_i, m1_wb_stb_i  input  1 each  master strobe
m0_wb_we_i, m1_wb_we_i  input  1 each  master write enable
m0_wb_adr_i, m1_wb_adr_i  input  ADDR_WIDTH each  master address
m0_wb_dat_i, m1_wb_dat_i  input  DATA_WIDTH each  master write data
m0_wb_sel_i, m1_wb_sel_i  input  DATA_WIDTH/8 each  master byte select
m0_wb_ack_o, m1_wb_ack_o  output  1 each  ack to master
m0_wb_dat_o, m1_wb_dat_o  output  DATA_WIDTH each  read data to master
s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  output  1 each  to slave
s_wb_adr_o  output  ADDR_WIDTH  to slave
s_wb_dat_o  output  DATA_WIDTH  to slave
s_wb_sel_o  output  DATA_WIDTH/8  to slave
s_wb_ack_i  input  1  slave ack
s_wb_dat_i  input  DATA_WIDTH  slave read data
grant_o  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = none
timeout_o  output  1  sticky watchdog flag

Behaviour:
- States: IDLE, BUS_M0, BUS_M1. grant_o decodes directly from state.
- Request definition: reqX = mX_wb_cyc_i & mX_wb_stb_i.
- Reset (reset=0, asynchronous):
  - state = IDLE, grant_o = 00, timeout_o = 0, watchdog counter = 0.
  - last-grant register = m1, so the first round-robin tie goes to m0.
- Arbitration latency: the grant is registered and takes effect one cycle after the request is sampled in IDLE.
- IDLE:
  - All s_wb_* outputs are 0; both mX_wb_ack_o are 0.
  - Only req0 -> BUS_M0. Only req1 -> BUS_M1.
  - Both requesting: RR_MODE=0 -> BUS_M1. RR_MODE=1 -> the master not equal to last-grant.
- BUS_Mx:
  - s_wb_cyc/stb/we/adr/dat/sel are combinationally driven from master x.
  - mX_wb_ack_o = s_wb_ack_i; the other master's ack is held 0.
  - m0_wb_dat_o and m1_wb_dat_o both = s_wb_dat_i (broadcast; only the acked master consumes it).
- Transfer end: s_wb_ack_i=1 in BUS_Mx -> IDLE next cycle; last-grant := x.
  - Bus turnaround is therefore at least 1 idle cycle between transfers.
- Abort: mX_wb_cyc_i falls in BUS_Mx without ack -> s_wb_cyc_o follows low the same cycle; state -> IDLE next cycle; last-grant unchanged.
- A request from the non-owner while BUS_Mx is busy is held pending and re-arbitrated in IDLE; it is never dropped.
- Reset asserted mid-transfer: s_wb_cyc_o/stb_o drop immediately (asynchronous); no ack is forwarded.
- A stray s_wb_ack_i in IDLE is ignored.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUS_Mx and increments each BUS_Mx cycle without s_wb_ack_i.
  - When it reaches TIMEOUT_CYCLES, the arbiter issues a one-cycle synthetic mX_wb_ack_o with mX_wb_dat_o = 0 and forces s_wb_cyc_o/stb_o = 0 that cycle.
  - It then sets timeout_o = 1 (sticky until reset) and goes to IDLE.
- Undefined: no counter is built, timeout_o is tied 0, and the arbiter waits indefinitely for ack.

Test Plan:
- m0 only, read adr 0x8000_0000, slave acks 2 cycles after s_wb_stb_o with 0x0000_0013 -> grant_o=01 one cycle after request; m0_wb_ack_o pulses once with data 0x0000_0013; m1_wb_ack_o stays 0.
- Both request in the same cycle, RR_MODE=0 -> m1 served first; m0 granted after the IDLE gap; repeat 4 times -> m1 always first.
- Both request continuously, RR_MODE=1 -> grant_o sequence 01, 10, 01, 10 across four transfers.
- m1 write adr 0x8010_0000, dat 0xDEAD_BEEF, sel 0xF -> s_wb_we_o=1 and slave sees the exact address, data and sel; m0 request held off until IDLE.
- reset driven 0 while BUS_M0 is waiting for ack -> s_wb_cyc_o=0 the same cycle; grant_o=00; after release, a fresh m0 request is served normally.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m0 -> m0_wb_ack_o pulses with data 0 on the 8th BUS_M0 cycle; timeout_o=1 and stays 1; a following m1 transfer completes normally.
